// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_pkg.sv
// Shared types and default sizing for the switched-cap bank enable sequencer.
package gf180mcu_fd_sc_mcu7t5v0__capbank_pkg;

  localparam int unsigned NSEG_DEF        = 8;
  localparam int unsigned STEP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_tmr.sv
// Step timer: modulo-STEP_CYCLES counter with synchronous clear.
// o_tick is high during the last count of each step period.
module gf180mcu_fd_sc_mcu7t5v0__capbank_tmr
  import gf180mcu_fd_sc_mcu7t5v0__capbank_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned     CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv
// Inrush-limiting enable sequencer: ramps NSEG cap-segment enables as a
// thermometer code, one segment per STEP_CYCLES clocks, under REQ/ACK.
module gf180mcu_fd_sc_mcu7t5v0__capbank_seq
  import gf180mcu_fd_sc_mcu7t5v0__capbank_pkg::*;
#(
  parameter  int unsigned NSEG        = NSEG_DEF,
  parameter  int unsigned STEP_CYCLES = STEP_CYCLES_DEF,
  localparam int unsigned LVL_W       = $clog2(NSEG + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWR_REQ,
  output logic [NSEG-1:0]  EN,
  output logic [LVL_W-1:0] LEVEL,
  output logic             PWR_ACK,
  output logic             BUSY
);

  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NSEG);

  state_e           r_state;
  logic [LVL_W-1:0] r_level;
  logic [NSEG-1:0]  r_en;
  logic             r_ack;
  logic             r_busy;

  logic             w_tick;
  logic             w_tmr_clr;
  logic [LVL_W-1:0] w_lvl_inc;
  logic [LVL_W-1:0] w_lvl_dec;

  // Timer only runs while ramping in the requested direction; any reversal
  // or settled state restarts the step period from zero.
  assign w_tmr_clr = !(((r_state == RAMP_UP) && PWR_REQ) ||
                       ((r_state == RAMP_DOWN) && !PWR_REQ));
  assign w_lvl_inc = r_level + LVL_ONE;
  assign w_lvl_dec = r_level - LVL_ONE;

  gf180mcu_fd_sc_mcu7t5v0__capbank_tmr #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tmr (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_tmr_clr),
    .o_tick (w_tick)
  );

  function automatic logic [NSEG-1:0] therm(input logic [LVL_W-1:0] lvl);
    logic [NSEG-1:0] t;
    for (int unsigned i = 0; i < NSEG; i++) begin
      t[i] = (LVL_W'(i) < lvl);
    end
    return t;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= OFF;
      r_level <= '0;
      r_en    <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          r_ack <= 1'b0;
          if (PWR_REQ) begin
            r_level <= LVL_ONE;
            r_en    <= therm(LVL_ONE);
            if (LVL_ONE == LVL_MAX) begin
              r_state <= ON;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RAMP_UP;
              r_busy  <= 1'b1;
            end
          end
        end
        RAMP_UP: begin
          if (!PWR_REQ) begin
            r_state <= RAMP_DOWN;
          end else if (w_tick && (r_level != LVL_MAX)) begin
            r_level <= w_lvl_inc;
            r_en    <= therm(w_lvl_inc);
            if (w_lvl_inc == LVL_MAX) begin
              r_state <= ON;
              r_busy  <= 1'b0;
            end
          end
        end
        ON: begin
          r_ack <= 1'b1;
          if (!PWR_REQ) begin
            r_level <= w_lvl_dec;
            r_en    <= therm(w_lvl_dec);
            if (w_lvl_dec == '0) begin
              r_state <= OFF;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RAMP_DOWN;
              r_busy  <= 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (PWR_REQ) begin
            r_state <= RAMP_UP;
          end else if (w_tick && (r_level != '0)) begin
            r_level <= w_lvl_dec;
            r_en    <= therm(w_lvl_dec);
            if (w_lvl_dec == '0) begin
              r_state <= OFF;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= OFF;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign EN      = r_en;
  assign LEVEL   = r_level;
  assign PWR_ACK = r_ack;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq.sv
// Self-checking bench for the cap-bank sequencer: NSEG=8/STEP=4 instance
// against a reference model, plus a NSEG=1/STEP=1 corner instance.
module tb_gf180mcu_fd_sc_mcu7t5v0__capbank_seq;

  localparam int N8 = 8;
  localparam int S8 = 4;

  typedef struct packed {
    logic [7:0] en;
    logic [3:0] lvl;
    logic       ack;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst8, req8, rst1, req1;
  logic [7:0] en8;
  logic [3:0] lvl8;
  logic       ack8, busy8;
  logic [0:0] en1;
  logic [0:0] lvl1;
  logic       ack1, busy1;

  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t q8[$];

  // Reference model state: mode 0=off 1=up 2=on 3=down
  int   m_level, m_age, m_mode;
  logic m_ack;

  // Monitor state
  logic       mon_on = 1'b0;
  logic       p_ack, p_busy, p_rst;
  logic [3:0] p_lvl;

  gf180mcu_fd_sc_mcu7t5v0__capbank_seq #(.NSEG(8), .STEP_CYCLES(4)) dut8 (
    .CLK(clk), .RST(rst8), .PWR_REQ(req8),
    .EN(en8), .LEVEL(lvl8), .PWR_ACK(ack8), .BUSY(busy8)
  );

  gf180mcu_fd_sc_mcu7t5v0__capbank_seq #(.NSEG(1), .STEP_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst1), .PWR_REQ(req1),
    .EN(en1), .LEVEL(lvl1), .PWR_ACK(ack1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic q);
    if (r) begin
      m_level = 0; m_age = 0; m_mode = 0; m_ack = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          m_ack = 1'b0;
          if (q) begin m_level = 1; m_age = 0; m_mode = (m_level == N8) ? 2 : 1; end
        end
        1: begin
          if (!q) begin m_mode = 3; m_age = 0; end
          else begin
            m_age++;
            if (m_age % S8 == 0) begin m_level++; if (m_level == N8) m_mode = 2; end
          end
        end
        2: begin
          m_ack = 1'b1;
          if (!q) begin m_level--; m_age = 0; m_mode = (m_level == 0) ? 0 : 3; end
        end
        default: begin
          if (q) begin m_mode = 1; m_age = 0; end
          else begin
            m_age++;
            if (m_age % S8 == 0) begin m_level--; if (m_level == 0) m_mode = 0; end
          end
        end
      endcase
    end
  endtask

  // Drive one edge on the 8-segment DUT, queue the model's prediction, compare after the edge
  task automatic cycle8(input logic r, input logic q);
    exp_t e;
    rst8 = r;
    req8 = q;
    model_step(r, q);
    e.en   = 8'((16'd1 << m_level) - 16'd1);
    e.lvl  = 4'(m_level);
    e.ack  = m_ack;
    e.busy = (m_mode == 1) || (m_mode == 3);
    q8.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = q8.pop_front();
    n_run++;
    if (en8 !== e.en) begin
      n_fail++; $display("FAIL en cyc=%0d got=%h exp=%h", cyc, en8, e.en);
    end
    n_run++;
    if (lvl8 !== e.lvl) begin
      n_fail++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, lvl8, e.lvl);
    end
    n_run++;
    if (ack8 !== e.ack) begin
      n_fail++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack8, e.ack);
    end
    n_run++;
    if (busy8 !== e.busy) begin
      n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy8, e.busy);
    end
  endtask

  // Per-edge invariants on the 8-segment DUT
  always @(posedge clk) begin
    logic [8:0] t;
    int         d;
    p_ack  = ack8;
    p_busy = busy8;
    p_lvl  = lvl8;
    p_rst  = rst8;
    #1;
    if (mon_on) begin
      t = {1'b0, en8} + 9'd1;
      n_run++;
      if ((t & {1'b0, en8}) != 9'd0) begin
        n_fail++; $display("FAIL thermo cyc=%0d got=%h exp=thermometer", cyc, en8);
      end
      n_run++;
      if (lvl8 !== 4'($countones(en8))) begin
        n_fail++; $display("FAIL popcount cyc=%0d got=%0d exp=%0d", cyc, lvl8, $countones(en8));
      end
      if (!p_rst) begin
        d = int'(lvl8) - int'(p_lvl);
        n_run++;
        if (d > 1 || d < -1) begin
          n_fail++; $display("FAIL dlevel cyc=%0d got=%0d exp=<=1", cyc, d);
        end
        n_run++;
        if (p_busy && (ack8 !== p_ack)) begin
          n_fail++; $display("FAIL ack_while_busy cyc=%0d got=%b exp=%b", cyc, ack8, p_ack);
        end
      end
    end
  end

  task automatic test_reset;
    cycle8(1'b1, 1'b1);
    cycle8(1'b1, 1'b0);
    n_run++;
    if ({en8, lvl8, ack8, busy8} !== 14'd0) begin
      n_fail++; $display("FAIL reset got=%h exp=0", {en8, lvl8, ack8, busy8});
    end
    mon_on = 1'b1;
  endtask

  task automatic test_ramp_up;
    logic [7:0] x;
    for (int e = 0; e < 30; e++) begin
      cycle8(1'b0, 1'b1);
      if (e % 4 == 0) begin
        x = 8'((16'd1 << (e / 4 + 1)) - 16'd1);
        n_run++;
        if (en8 !== x) begin
          n_fail++; $display("FAIL up_step e=%0d got=%h exp=%h", e, en8, x);
        end
      end
    end
    n_run++;
    if (ack8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL up_done got=ack%b busy%b exp=ack1 busy0", ack8, busy8);
    end
  endtask

  task automatic test_ramp_down;
    logic [7:0] x;
    for (int e = 0; e < 30; e++) begin
      cycle8(1'b0, 1'b0);
      if (e % 4 == 0) begin
        x = 8'((16'd1 << (7 - e / 4)) - 16'd1);
        n_run++;
        if (en8 !== x) begin
          n_fail++; $display("FAIL down_step e=%0d got=%h exp=%h", e, en8, x);
        end
      end
    end
    n_run++;
    if (ack8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL down_done got=ack%b busy%b exp=ack0 busy0", ack8, busy8);
    end
  endtask

  task automatic test_reversal;
    logic [7:0] x;
    for (int e = 0; e < 23; e++) begin
      cycle8(1'b0, e < 9);
      if (e >= 9) begin
        x = (e <= 12) ? 8'h07 : (e <= 16) ? 8'h03 : (e <= 20) ? 8'h01 : 8'h00;
        n_run++;
        if (en8 !== x) begin
          n_fail++; $display("FAIL reversal e=%0d got=%h exp=%h", e, en8, x);
        end
      end
      n_run++;
      if (ack8 !== 1'b0) begin
        n_fail++; $display("FAIL reversal_ack e=%0d got=%b exp=0", e, ack8);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int e = 0; e < 10; e++) cycle8(1'b0, 1'b1);
    n_run++;
    if (en8 !== 8'h07) begin
      n_fail++; $display("FAIL pre_rst got=%h exp=07", en8);
    end
    cycle8(1'b1, 1'b1);
    n_run++;
    if (en8 !== 8'h00 || lvl8 !== 4'd0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got=%h/%0d/%b exp=00/0/0", en8, lvl8, busy8);
    end
    cycle8(1'b0, 1'b1);
    n_run++;
    if (en8 !== 8'h01) begin
      n_fail++; $display("FAIL restart got=%h exp=01", en8);
    end
    for (int e = 0; e < 34; e++) cycle8(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic q;
    logic r;
    q = req8;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) q = ~q;
      r = ($urandom_range(0, 149) == 0);
      cycle8(r, q);
    end
  endtask

  task automatic test_nseg1;
    rst1 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (en1 !== 1'b0 || ack1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL n1_reset got=%b%b%b exp=000", en1, ack1, busy1);
    end
    rst1 = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if (en1 !== 1'b1 || lvl1 !== 1'b1 || busy1 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++; $display("FAIL n1_on got=en%b lvl%b busy%b ack%b exp=1100", en1, lvl1, busy1, ack1);
    end
    @(posedge clk); #1;
    n_run++;
    if (ack1 !== 1'b1) begin
      n_fail++; $display("FAIL n1_ack got=%b exp=1", ack1);
    end
    req1 = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if (en1 !== 1'b0 || busy1 !== 1'b0 || ack1 !== 1'b1) begin
      n_fail++; $display("FAIL n1_off got=en%b busy%b ack%b exp=001", en1, busy1, ack1);
    end
    @(posedge clk); #1;
    n_run++;
    if (ack1 !== 1'b0) begin
      n_fail++; $display("FAIL n1_ack_drop got=%b exp=0", ack1);
    end
  endtask

  initial begin
    rst8 = 1'b1; req8 = 1'b0;
    rst1 = 1'b1; req1 = 1'b0;
    m_level = 0; m_age = 0; m_mode = 0; m_ack = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_reset_mid();
    test_back_to_back();
    test_nseg1();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
